demux4_stream: RTL and testbench

- 1-to-4 registered stream demultiplexer; the inverse of the team's 4:1 mux (i0..i3, s1/s0 → y).
- Accepts one input word per handshake and routes it to one of four outputs.
- Destination comes from s1/s0 or from an internal round-robin pointer.
- Each output has a one-entry holding register with its own valid/ready, so a stalled output blocks only traffic aimed at it.
- Sits downstream of the mux path in the datapath.

---
 rtl/demux4_stream_pkg.sv | 13 +
 rtl/demux4_stream_if.sv | 30 +++
 rtl/demux4_stream_slot.sv | 29 ++
 rtl/demux4_stream.sv | 63 ++++++
 tb/tb_demux4_stream.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/demux4_stream_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
package demux4_stream_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] sel_t;

    localparam sel_t CH0 = 2'd0;
    localparam sel_t CH1 = 2'd1;
    localparam sel_t CH2 = 2'd2;
    localparam sel_t CH3 = 2'd3;

endpackage

// File: rtl/demux4_stream_if.sv
// Handshake and data bundle for demux4_stream; slave is the demux side, master the producer/consumer side.
interface demux4_stream_if
    import demux4_stream_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]  din;
    logic              din_valid;
    logic              din_ready;
    logic              s1;
    logic              s0;
    logic              rr_en;
    logic [WIDTH-1:0]  y0;
    logic [WIDTH-1:0]  y1;
    logic [WIDTH-1:0]  y2;
    logic [WIDTH-1:0]  y3;
    logic [NUM_CH-1:0] y_valid;
    logic [NUM_CH-1:0] y_ready;
    sel_t              rr_ptr;

    modport slave (
        input  din, din_valid, s1, s0, rr_en, y_ready,
        output din_ready, y0, y1, y2, y3, y_valid, rr_ptr
    );

    modport master (
        output din, din_valid, s1, s0, rr_en, y_ready,
        input  din_ready, y0, y1, y2, y3, y_valid, rr_ptr
    );
endinterface

// File: rtl/demux4_stream_slot.sv
// One-entry output holding register with full flag.
// Latency: loaded word visible the cycle after load.
// Backpressure: full stays set until ready; a same-cycle load wins over drain.
module demux_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_dat,
    input  logic             drain_rdy,
    output logic             full,
    output logic [WIDTH-1:0] dat
);

    // Data is only overwritten by a load, so it persists after drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full <= 1'b0;
            dat  <= '0;
        end else if (load) begin
            full <= 1'b1;
            dat  <= load_dat;
        end else if (drain_rdy) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/demux4_stream.sv
// 1-to-4 registered stream demux, destination from {s1,s0} or round-robin pointer.
// Latency: one cycle from accept to y_valid on the target channel.
// Backpressure: only the target slot gates din_ready; round-robin blocks, never skips.
module demux4_stream
    import demux4_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    demux4_stream_if.slave    bus
);

    sel_t              tgt;
    sel_t              rr_ptr_q;
    logic              accept;
    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] full;
    logic [WIDTH-1:0]  y_dat [NUM_CH];

    assign tgt = bus.rr_en ? rr_ptr_q : {bus.s1, bus.s0};

    // Ready looks through to the consumer so a full slot can drain and refill in one cycle.
    assign bus.din_ready = rst_n & (~full[tgt] | bus.y_ready[tgt]);
    assign accept        = bus.din_valid & bus.din_ready;

    always_comb begin
        load = '0;
        if (accept) begin
            load[tgt] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q <= CH0;
        end else if (accept && bus.rr_en) begin
            rr_ptr_q <= rr_ptr_q + sel_t'(1);
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load[k]),
            .load_dat (bus.din),
            .drain_rdy(bus.y_ready[k]),
            .full     (full[k]),
            .dat      (y_dat[k])
        );
    end

    assign bus.y_valid = full;
    assign bus.y0      = y_dat[CH0];
    assign bus.y1      = y_dat[CH1];
    assign bus.y2      = y_dat[CH2];
    assign bus.y3      = y_dat[CH3];
    assign bus.rr_ptr  = rr_ptr_q;

endmodule

// File: tb/tb_demux4_stream.sv
// Directed and random stimulus for demux4_stream against a per-channel occupancy model.
module tb_demux4_stream;

    logic clk;
    logic rst_n;

    demux4_stream_if #(.WIDTH(8)) bus ();

    demux4_stream #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // Reference: undelivered word count and last word written per channel, plus pointer.
    int         m_cnt [4];
    logic [7:0] m_dat [4];
    int         m_ptr;
    bit         checking = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] d,
                        input logic [1:0] sel, input logic rr, input logic [3:0] yr);
        int         tgt;
        logic       exp_rdy;
        logic [3:0] exp_vld;
        rst_n         = r;
        bus.din_valid = v;
        bus.din       = d;
        bus.s1        = sel[1];
        bus.s0        = sel[0];
        bus.rr_en     = rr;
        bus.y_ready   = yr;
        #1;
        tgt     = rr ? m_ptr : int'(sel);
        exp_rdy = r && (m_cnt[tgt] == 0 || yr[tgt]);
        for (int k = 0; k < 4; k++) exp_vld[k] = (m_cnt[k] != 0);
        if (checking) begin
            chk("din_ready", 32'(bus.din_ready), 32'(exp_rdy));
            chk("y_valid",   32'(bus.y_valid),   32'(exp_vld));
            chk("rr_ptr",    32'(bus.rr_ptr),    32'(m_ptr));
            chk("y0",        32'(bus.y0),        32'(m_dat[0]));
            chk("y1",        32'(bus.y1),        32'(m_dat[1]));
            chk("y2",        32'(bus.y2),        32'(m_dat[2]));
            chk("y3",        32'(bus.y3),        32'(m_dat[3]));
        end
        @(posedge clk);
        if (!r) begin
            for (int k = 0; k < 4; k++) begin
                m_cnt[k] = 0;
                m_dat[k] = 8'h00;
            end
            m_ptr    = 0;
            checking = 1'b1;
        end else begin
            for (int k = 0; k < 4; k++)
                if (m_cnt[k] > 0 && yr[k]) m_cnt[k]--;
            if (v && exp_rdy) begin
                m_cnt[tgt]++;
                m_dat[tgt] = d;
                if (rr) m_ptr = (m_ptr + 1) % 4;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            m_cnt[k] = 0;
            m_dat[k] = 8'h00;
        end
        m_ptr = 0;

        // Reset held with din_valid high.
        step(1'b0, 1'b1, 8'hEE, 2'b00, 1'b0, 4'hF);
        step(1'b0, 1'b1, 8'hEE, 2'b00, 1'b0, 4'hF);
        chk("rst_ready_low", 32'(bus.din_ready), 32'd0);

        // Static select to each channel.
        step(1'b1, 1'b1, 8'hA0, 2'b00, 1'b0, 4'hF);
        step(1'b1, 1'b1, 8'hA1, 2'b01, 1'b0, 4'hF);
        step(1'b1, 1'b1, 8'hA2, 2'b10, 1'b0, 4'hF);
        step(1'b1, 1'b1, 8'hA3, 2'b11, 1'b0, 4'hF);
        chk("static_y3", 32'(bus.y3), 32'h0A3);
        step(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 4'hF);
        chk("static_ptr", 32'(bus.rr_ptr), 32'd0);

        // Round-robin wrap.
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b1, 8'(8'h10 + i), 2'b11, 1'b1, 4'hF);
        step(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 4'hF);
        chk("rr_end_ptr", 32'(bus.rr_ptr), 32'd2);
        chk("rr_y0",      32'(bus.y0),     32'h014);
        chk("rr_y1",      32'(bus.y1),     32'h015);

        // Backpressure isolation, then drain-and-refill on channel 1.
        step(1'b1, 1'b1, 8'h55, 2'b01, 1'b0, 4'h0);
        step(1'b1, 1'b1, 8'h88, 2'b01, 1'b0, 4'h0);
        step(1'b1, 1'b1, 8'h66, 2'b10, 1'b0, 4'h0);
        step(1'b1, 1'b1, 8'h77, 2'b01, 1'b0, 4'b0010);
        chk("refill_y1",    32'(bus.y1),         32'h077);
        chk("refill_vld1",  32'(bus.y_valid[1]), 32'd1);
        step(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 4'hF);

        // Mode switch: pointer holds while rr_en is low.
        step(1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 4'hF);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 8'(8'hB0 + i), 2'b00, 1'b1, 4'hF);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 8'(8'hC0 + i), 2'b00, 1'b0, 4'hF);
        chk("mode_hold_ptr", 32'(bus.rr_ptr), 32'd3);
        step(1'b1, 1'b1, 8'hD3, 2'b00, 1'b1, 4'hF);
        chk("mode_y3",   32'(bus.y3),     32'h0D3);
        chk("mode_wrap", 32'(bus.rr_ptr), 32'd0);
        step(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 4'hF);

        // Reset mid-operation with y_valid = 1011.
        step(1'b1, 1'b1, 8'h31, 2'b00, 1'b0, 4'h0);
        step(1'b1, 1'b1, 8'h32, 2'b01, 1'b0, 4'h0);
        step(1'b1, 1'b1, 8'h33, 2'b11, 1'b0, 4'h0);
        chk("pre_rst_vld", 32'(bus.y_valid), 32'b1011);
        step(1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 4'h0);
        chk("post_rst_vld", 32'(bus.y_valid), 32'd0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 4'hF);

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) != 0), 1'($urandom), 8'($urandom),
                 2'($urandom), 1'($urandom), 4'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
